// File: rtl/shift_add_multiplier_8bit_pkg.sv
// Shared constants for the shift-add multiplier: operand/product widths,
// step counter sizing and the FSM state encoding.
package shift_add_multiplier_8bit_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

  // Index of the last CALC step; the step at this count moves to DONE.
  localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier_8bit_cla.sv
// Carry_Look_Ahead_Adder_8bit: 8-bit carry-lookahead adder.
// Ports (in order):
//   a, b  [7:0] addends
//   cin         carry in
//   sum   [7:0] a + b + cin, low 8 bits
//   cout        carry out
// Every carry is expanded directly from generate/propagate terms and cin,
// so no carry depends on another carry.
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen;
  logic [7:0] prop;
  logic [8:0] carry;
  logic       term;

  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    carry = '0;
    term  = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      // carry[i+1] = OR_j (g[j] & p[j+1..i])  |  (cin & p[0..i])
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        carry[i+1] = carry[i+1] | term;
      end
      term = cin;
      for (int k = 0; k <= i; k++) begin
        term = term & prop[k];
      end
      carry[i+1] = carry[i+1] | term;
    end
    sum  = prop ^ carry[7:0];
    cout = carry[8];
  end

endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// shift_add_multiplier_8bit: sequential unsigned 8x8 multiplier, one partial
// product per cycle (IDLE -> 8 x CALC -> DONE -> IDLE, 9 cycles per product).
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request; only looked at in IDLE
//   a, b   [7:0] multiplicand / multiplier, captured with an accepted start
//   busy         high in CALC and DONE
//   done         one-cycle pulse in DONE, p valid
//   p     [15:0] product, held until the next completion or reset
// Handshake: start is accepted on an edge where the block is in IDLE (busy=0);
// a and b are only sampled on that edge. start while busy is dropped.
module shift_add_multiplier_8bit
  import shift_add_multiplier_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  state_e             state_q,  state_d;
  logic [OP_W-1:0]    mcand_q,  mcand_d;
  logic [OP_W-1:0]    acc_q,    acc_d;
  logic [OP_W-1:0]    mpl_q,    mpl_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [PROD_W-1:0]  p_q,      p_d;

  logic [OP_W-1:0]    addend;
  logic [OP_W-1:0]    sum;
  logic               cout;

  assign addend = mpl_q[0] ? mcand_q : '0;

  Carry_Look_Ahead_Adder_8bit u_cla (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The working register is {c, acc, mpl}. c is always 0 after every load
  // (the adder carry shifts into acc[7]), so it is not stored.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mpl_d   = mpl_q;
    count_d = count_q;
    p_d     = p_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = '0;
          mpl_d   = b;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        // {cout,sum,mpl} shifted right by one
        {acc_d, mpl_d} = {cout, sum, mpl_q[OP_W-1:1]};
        count_d        = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          p_d     = {cout, sum, mpl_q[OP_W-1:1]};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mpl_q   <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mpl_q   <= mpl_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign p    = p_q;

endmodule

// File: doc/shift_add_multiplier_8bit.md
SHIFT_ADD_MULTIPLIER_8BIT -- requirements
Module: shift_add_multiplier_8bit

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 8 bits, product width at 16 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  8  multiplicand, unsigned; sampled with accepted start.
REQ-006 b  input  8  multiplier, unsigned; sampled with accepted start.
REQ-007 busy  output  1  high while in CALC or DONE.
REQ-008 done  output  1  one-cycle pulse; p valid.
REQ-009 p  output  16  product a*b, unsigned; held until next completion or reset.

Function
REQ-010 FSM SHALL have states IDLE, CALC, DONE; reset state IDLE.
REQ-011 IDLE: start=1 at edge T SHALL latch a into mcand, b into the low half of the 17-bit working register {c, acc[7:0], mpl[7:0]} with c=0 and acc=0, clear count to 0, and go to CALC.
REQ-012 IDLE with start=0 SHALL hold all registers.
REQ-013 Each CALC edge SHALL form {cout,sum} = acc + (mpl[0] ? mcand : 8'h00) with cin=0 via the 8-bit CLA adder.
REQ-014 Each CALC edge SHALL then load {c,acc,mpl} <= {1'b0, cout, sum, mpl[7:1]}, i.e. {cout,sum,mpl} shifted right by one bit, and increment count.
REQ-015 CALC SHALL last exactly 8 edges (T+1..T+8); at the edge where count reaches 7 the step executes and the state goes to DONE.
REQ-016 Entering DONE SHALL load p <= {acc,mpl} of the final step; done=1 for the single DONE cycle (between edges T+8 and T+9).
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally; start is first accepted at edge T+9; throughput is one product per 9 cycles.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no effect on the in-flight operation.
REQ-019 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-020 The result SHALL be exact for all 65536 operand pairs; maximum 255*255 = 16'hFE01, with no overflow possible.
REQ-021 done SHALL be 0 in IDLE and CALC.
REQ-022 busy SHALL be 0 in IDLE.
REQ-023 p SHALL change only on entry to DONE or on reset.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, p=0, done=0, busy=0, count=0 and working register=0, overriding start.
REQ-025 rst during CALC or DONE SHALL abort the operation; no done pulse is produced for it.
REQ-026 After rst deasserts, start SHALL be accepted on the first edge.

Structure
REQ-027 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and widths (8, 16) SHALL live in the shared lab constants include, not local literals.
REQ-028 The adder SHALL be one instance of the existing Carry_Look_Ahead_Adder_8bit with port order (a, b, cin, sum, cout) and cin tied to 0.
REQ-029 The module SHALL contain no other arithmetic operators on the datapath; the counter is the only other incrementer.

Verification
REQ-030 Operands a=3, b=5, start pulse -> done exactly 9 edges after the accepting edge, p=16'd15, busy high for 9 cycles.
REQ-031 Operands a=8'hFF, b=8'hFF -> p=16'hFE01; then a=8'h00, b=8'hAB -> p=16'h0000.
REQ-032 start held high continuously with a=12, b=10 -> products accepted every 9 cycles, each p=16'd120, done pulses one cycle wide.
REQ-033 start asserted mid-CALC with new operands 7,7 -> ignored, first result unchanged, no extra done.
REQ-034 rst asserted at CALC step 4 -> next cycle IDLE, p=0, done never pulses; fresh start a=2, b=9 -> p=16'd18.
REQ-035 Exhaustive sweep over all a and b -> {p} === a*b at every done pulse, and error flag stays 0.
